// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART scheduler.
// Contents:
//   sched_state_t     - scheduler FSM states
//   UART_ADDR_DEFAULT - default APB address of the UART slave
//   tmo_cnt_width()   - width of the ACCESS timeout counter
package apb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  localparam logic [31:0] UART_ADDR_DEFAULT = 32'h0000_0000;

  // The counter runs 0 .. timeout-1, so $clog2(timeout) bits are enough.
  function automatic int tmo_cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/apb_uart_rr_arb.sv
// Combinational round-robin picker.
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - index of the most recently served requester
//   grant   - first requesting index searching upward from ptr+1 (wraps mod NREQ)
//   any_req - at least one request bit is high
module apb_uart_rr_arb
  import apb_uart_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    any_req
);

  localparam int GW = $clog2(NREQ);

  // Search upward from ptr+1; the last-served requester is checked last.
  always_comb begin
    logic          found_s;
    logic [GW-1:0] idx_s;
    grant   = ptr;
    found_s = 1'b0;
    idx_s   = ptr;
    any_req = |req;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = GW'((int'(ptr) + k) % NREQ);
      if (!found_s && req[idx_s]) begin
        grant   = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/apb_uart_sched.sv
// Round-robin scheduler sharing one APB UART slave between NREQ requesters.
// Ports:
//   pclk, presetn              - APB clock, async active-low reset
//   req/req_write/req_wdata    - per-requester request, direction, write byte
//   done                       - one-cycle completion pulse to the granted requester
//   rsp_rdata/rsp_err          - read byte / timeout flag, valid in the done cycle
//   m_psel..m_pwdata           - APB master outputs (all registered)
//   m_prdata/m_pready          - APB slave response
//   m_pwakeup                  - slave wakeup, informational only
module apb_uart_sched
  import apb_uart_pkg::*;
#(
  parameter int          NREQ      = 4,
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] UART_ADDR = UART_ADDR_DEFAULT
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_write,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              m_psel,
  output logic              m_penable,
  output logic              m_pwrite,
  output logic [31:0]       m_paddr,
  output logic [7:0]        m_pwdata,
  input  logic [7:0]        m_prdata,
  input  logic              m_pready,
  input  logic              m_pwakeup
);

  localparam int          GW   = $clog2(NREQ);
  localparam int          CW   = tmo_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  sched_state_t    state_r, state_s;
  logic [GW-1:0]   ptr_r, ptr_s;
  logic [GW-1:0]   grant_r, grant_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [NREQ-1:0] done_r, done_s;
  logic [7:0]      rdata_r, rdata_s;
  logic            err_r, err_s;
  logic            psel_r, psel_s;
  logic            penable_r, penable_s;
  logic            pwrite_r, pwrite_s;
  logic [31:0]     paddr_r, paddr_s;
  logic [7:0]      pwdata_r, pwdata_s;

  logic [GW-1:0]   pick_s;
  logic            any_req_s;

  // Wakeup has no behavioural effect; it only qualifies the busy indication.
  logic unused_busy_s;
  assign unused_busy_s = m_pwakeup & (state_r != IDLE);

  apb_uart_rr_arb #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .ptr     (ptr_r),
    .grant   (pick_s),
    .any_req (any_req_s)
  );

  // State and output registers; reset drops the APB strobes immediately.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r   <= IDLE;
      ptr_r     <= GW'(NREQ - 1);
      grant_r   <= '0;
      cnt_r     <= '0;
      done_r    <= '0;
      rdata_r   <= 8'h00;
      err_r     <= 1'b0;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= 32'h0000_0000;
      pwdata_r  <= 8'h00;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      grant_r   <= grant_s;
      cnt_r     <= cnt_s;
      done_r    <= done_s;
      rdata_r   <= rdata_s;
      err_r     <= err_s;
      psel_r    <= psel_s;
      penable_r <= penable_s;
      pwrite_r  <= pwrite_s;
      paddr_r   <= paddr_s;
      pwdata_r  <= pwdata_s;
    end
  end

  // Next-state and next-output logic; the registered values move one cycle ahead
  // of the state they belong to (e.g. done is set on the ACCESS->DONE edge).
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    grant_s   = grant_r;
    cnt_s     = cnt_r;
    done_s    = '0;
    rdata_s   = rdata_r;
    err_s     = err_r;
    psel_s    = psel_r;
    penable_s = penable_r;
    pwrite_s  = pwrite_r;
    paddr_s   = paddr_r;
    pwdata_s  = pwdata_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          grant_s   = pick_s;
          pwrite_s  = req_write[pick_s];
          pwdata_s  = req_wdata[{pick_s, 3'b000} +: 8];
          paddr_s   = UART_ADDR;
          psel_s    = 1'b1;
          penable_s = 1'b0;
          state_s   = SETUP;
        end else begin
          psel_s    = 1'b0;
          penable_s = 1'b0;
        end
      end
      SETUP: begin
        penable_s = 1'b1;
        cnt_s     = '0;
        state_s   = ACCESS;
      end
      ACCESS: begin
        // pready takes precedence over a coincident timeout.
        if (m_pready) begin
          rdata_s         = pwrite_r ? 8'h00 : m_prdata;
          err_s           = 1'b0;
          psel_s          = 1'b0;
          penable_s       = 1'b0;
          done_s[grant_r] = 1'b1;
          state_s         = DONE;
        end else if (cnt_r == LAST) begin
          rdata_s         = 8'h00;
          err_s           = 1'b1;
          psel_s          = 1'b0;
          penable_s       = 1'b0;
          done_s[grant_r] = 1'b1;
          state_s         = DONE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DONE: begin
        psel_s    = 1'b0;
        penable_s = 1'b0;
        ptr_s     = grant_r;
        state_s   = IDLE;
      end
      default: begin
        psel_s    = 1'b0;
        penable_s = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  assign done      = done_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
  assign m_psel    = psel_r;
  assign m_penable = penable_r;
  assign m_pwrite  = pwrite_r;
  assign m_paddr   = paddr_r;
  assign m_pwdata  = pwdata_r;

endmodule

// File: tb/tb_apb_uart_sched.sv
// Directed, table-driven bench for apb_uart_sched (NREQ=4, TIMEOUT=16).
module tb_apb_uart_sched;

  localparam int          NREQ = 4;
  localparam int          TMO  = 16;
  localparam logic [31:0] ADDR = 32'h4000_1000;

  logic        pclk;
  logic        presetn;
  logic [3:0]  req;
  logic [3:0]  req_write;
  logic [31:0] req_wdata;
  logic [3:0]  done;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_paddr;
  logic [7:0]  m_pwdata;
  logic [7:0]  m_prdata;
  logic        m_pready;
  logic        m_pwakeup;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [31:0] wdata;
    int          lat;    // ACCESS cycle index in which pready is driven; -1 = never
    logic [7:0]  prdata;
    int          gnt;    // expected grant
    logic        pwr;    // expected m_pwrite
    logic [7:0]  pwd;    // expected m_pwdata
    logic [7:0]  rdata;  // expected rsp_rdata
    logic        err;    // expected rsp_err
    int          acc;    // expected number of ACCESS cycles
  } vec_t;

  vec_t vecs[13];

  apb_uart_sched #(.NREQ(NREQ), .TIMEOUT(TMO), .UART_ADDR(ADDR)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req       (req),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .done      (done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready),
    .m_pwakeup (m_pwakeup)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w, input logic [31:0] wd,
                              input int lat, input logic [7:0] prd, input int gnt,
                              input logic pwr, input logic [7:0] pwd, input logic [7:0] rd,
                              input logic err, input int acc);
    vec_t v;
    v.req = r; v.wr = w; v.wdata = wd; v.lat = lat; v.prdata = prd;
    v.gnt = gnt; v.pwr = pwr; v.pwd = pwd; v.rdata = rd; v.err = err; v.acc = acc;
    return v;
  endfunction

  // Called at #1 after a posedge with the DUT in IDLE; returns in the following IDLE cycle.
  task automatic run_vec(input vec_t v, input int id);
    int         c;
    logic       glitch;
    logic [3:0] exp_done;
    exp_done  = 4'b0001 << v.gnt;
    req       = v.req;
    req_write = v.wr;
    req_wdata = v.wdata;
    @(posedge pclk); #1;
    chk($sformatf("v%0d setup", id), 64'({m_psel, m_penable, m_pwrite, m_pwdata, m_paddr}),
        64'({1'b1, 1'b0, v.pwr, v.pwd, ADDR}));
    @(posedge pclk); #1;
    chk($sformatf("v%0d access", id), 64'({m_psel, m_penable, m_pwrite, m_pwdata, m_paddr}),
        64'({1'b1, 1'b1, v.pwr, v.pwd, ADDR}));
    c      = 0;
    glitch = 1'b0;
    while (done == 4'b0000 && c < 40) begin
      if (!(m_psel && m_penable) || m_pwdata !== v.pwd) glitch = 1'b1;
      m_pready = (c == v.lat);
      m_prdata = v.prdata;
      @(posedge pclk); #1;
      c++;
    end
    m_pready = 1'b0;
    m_prdata = 8'h00;
    chk($sformatf("v%0d access_cycles", id), 64'(c), 64'(v.acc));
    chk($sformatf("v%0d penable_held", id), 64'(glitch), 64'(0));
    chk($sformatf("v%0d done", id), 64'({done, m_psel, m_penable}), 64'({exp_done, 2'b00}));
    chk($sformatf("v%0d rdata", id), 64'(rsp_rdata), 64'(v.rdata));
    chk($sformatf("v%0d err", id), 64'(rsp_err), 64'(v.err));
    @(posedge pclk); #1;
    chk($sformatf("v%0d idle_hold", id), 64'({done, m_psel, rsp_rdata, rsp_err}),
        64'({4'b0000, 1'b0, v.rdata, v.err}));
  endtask

  initial begin
    logic [31:0] fw;
    n_vec     = 0;
    n_bad     = 0;
    presetn   = 1'b0;
    req       = 4'b0000;
    req_write = 4'b0000;
    req_wdata = 32'h0000_0000;
    m_prdata  = 8'h00;
    m_pready  = 1'b0;
    m_pwakeup = 1'b0;

    fw = 32'h4433_2211;
    //            req      wr       wdata           lat prdata gnt pwr  pwd    rdata  err  acc
    vecs[0]  = mk(4'b0001, 4'b0001, 32'h0000_00A5,  11, 8'h77, 0, 1'b1, 8'hA5, 8'h00, 1'b0, 12);
    vecs[1]  = mk(4'b0100, 4'b0000, 32'h005A_0000,   3, 8'h3C, 2, 1'b0, 8'h5A, 8'h3C, 1'b0, 4);
    vecs[2]  = mk(4'b1000, 4'b0000, fw,              0, 8'h81, 3, 1'b0, 8'h44, 8'h81, 1'b0, 1);
    vecs[3]  = mk(4'b1111, 4'b1010, fw,              0, 8'hC0, 0, 1'b0, 8'h11, 8'hC0, 1'b0, 1);
    vecs[4]  = mk(4'b1111, 4'b1010, fw,              1, 8'hC1, 1, 1'b1, 8'h22, 8'h00, 1'b0, 2);
    vecs[5]  = mk(4'b1111, 4'b1010, fw,              2, 8'hC2, 2, 1'b0, 8'h33, 8'hC2, 1'b0, 3);
    vecs[6]  = mk(4'b1111, 4'b1010, fw,              0, 8'hC3, 3, 1'b1, 8'h44, 8'h00, 1'b0, 1);
    vecs[7]  = mk(4'b1111, 4'b1010, fw,              1, 8'h0F, 0, 1'b0, 8'h11, 8'h0F, 1'b0, 2);
    vecs[8]  = mk(4'b1001, 4'b1010, fw,              0, 8'h99, 3, 1'b1, 8'h44, 8'h00, 1'b0, 1);
    vecs[9]  = mk(4'b1001, 4'b1010, fw,              2, 8'h5D, 0, 1'b0, 8'h11, 8'h5D, 1'b0, 3);
    vecs[10] = mk(4'b0010, 4'b0000, fw,             -1, 8'hEE, 1, 1'b0, 8'h22, 8'h00, 1'b1, 16);
    vecs[11] = mk(4'b0110, 4'b0100, fw,              2, 8'h12, 2, 1'b1, 8'h33, 8'h00, 1'b0, 3);
    vecs[12] = mk(4'b0001, 4'b0000, fw,             15, 8'hE7, 0, 1'b0, 8'h11, 8'hE7, 1'b0, 16);

    // Reset state.
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_outputs", 64'({done, rsp_rdata, rsp_err, m_psel, m_penable, m_pwrite, m_pwdata, m_paddr}),
        64'(0));
    presetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      m_pwakeup = (i % 2 == 1);
      run_vec(vecs[i], i);
    end
    m_pwakeup = 1'b0;

    // Reset in the middle of an ACCESS phase of a write from requester 2.
    req       = 4'b0100;
    req_write = 4'b0100;
    req_wdata = 32'h0066_0000;
    repeat (4) @(posedge pclk);
    #1;
    chk("pre_reset_access", 64'({m_psel, m_penable, m_pwdata}), 64'({1'b1, 1'b1, 8'h66}));
    req     = 4'b0101;
    presetn = 1'b0;
    #1;
    chk("async_reset_drop", 64'({m_psel, m_penable, done}), 64'(0));
    for (int k = 0; k < 2; k++) begin
      @(posedge pclk); #1;
      chk($sformatf("reset_hold%0d", k), 64'({m_psel, m_penable, done}), 64'(0));
    end
    presetn = 1'b1;
    chk("post_reset_no_done", 64'({done, rsp_err, rsp_rdata}), 64'(0));
    // Pointer back at NREQ-1, so requester 0 wins over requester 2.
    run_vec(mk(4'b0101, 4'b0101, 32'h0066_0011, 1, 8'hAB, 0, 1'b1, 8'h11, 8'h00, 1'b0, 2), 13);
    req = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_uart_sched.md
Name: apb_uart_sched

Overview:
- Round-robin scheduler that shares one APB UART slave between NREQ local requesters.
- Each requester posts a byte write (TX) or a byte read (RX) over a req/done handshake.
- The block arbitrates between requesters, runs the APB SETUP/ACCESS sequence as the UART's APB master, and returns read data or a timeout error.
- Sits between the subsystem's client logic and the UART's APB slave port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max ACCESS cycles waiting for m_pready before abort (≥ 16).
- UART_ADDR, 32'h0000_0000, value driven on m_paddr for every transfer.

Ports:
- pclk  in  1  APB clock; the only clock.
- presetn  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request; held high until its done pulse.
- req_write  in  NREQ  1 = write (TX), 0 = read (RX); stable while req is high.
- req_wdata  in  8*NREQ  write byte, slice i for requester i; stable while req is high.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  8  read byte, valid in the done cycle.
- rsp_err  out  1  timeout flag, valid in the done cycle.
- m_psel  out  1  APB select.
- m_penable  out  1  APB enable.
- m_pwrite  out  1  APB write.
- m_paddr  out  32  APB address (= UART_ADDR).
- m_pwdata  out  8  APB write data.
- m_prdata  in  8  APB read data.
- m_pready  in  1  APB ready.
- m_pwakeup  in  1  slave wakeup; informational only, routed to the busy logic.

Behaviour:
- Reset (presetn = 0, asynchronous):
  - All outputs 0; state IDLE; rr pointer = NREQ-1, so requester 0 has first priority; timeout counter 0.
  - Reset mid-transfer drops m_psel/m_penable immediately; no done pulse is generated.
- All outputs are registered.
- FSM, states IDLE, SETUP, ACCESS, DONE:
  - IDLE: if any req bit is high, grant the first requester searching upward from ptr+1 with wrap-around (mod NREQ). Latch grant index, req_write and req_wdata; drive m_psel=1, m_penable=0, m_pwrite and m_pwdata from the latched values. Go to SETUP.
  - SETUP: exactly one cycle. Drive m_penable=1, clear the timeout counter, go to ACCESS.
  - ACCESS: hold m_psel=m_penable=1 and the address/data stable.
    - If m_pready=1: capture m_prdata (reads only; writes capture 8'h00), rsp_err=0, go to DONE.
    - Otherwise, when the counter reaches TIMEOUT-1: rsp_err=1, rsp_rdata=0, go to DONE.
    - Otherwise increment the counter.
  - DONE: m_psel=m_penable=0; done[grant]=1 for this single cycle; ptr <= grant. Go to IDLE.
- Minimum back-to-back spacing is one idle APB cycle (DONE) plus IDLE. This gives the slave its return-to-idle gap; m_psel is never high on the cycle after m_pready.
- The slave restarts its check window every few cycles, so m_penable must stay high through ACCESS and never be toggled.
- If m_pready and the timeout coincide on the same cycle, m_pready wins and rsp_err=0.
- req is sampled only in IDLE.
  - A requester that deasserts req before its grant is simply skipped.
  - A requester that keeps req high after done is re-eligible, at lowest priority.
- A read with rx held idle-high never returns pready; that case resolves via timeout.
- rsp_rdata and rsp_err hold their values until the next DONE.
- A requester's data is guaranteed only in the cycle its done bit is high.
- Grant index width is $clog2(NREQ); pointer increment wraps NREQ-1 → 0.

Decomposition:
- Shared package apb_uart_pkg:
  - state enum sched_state_t {IDLE, SETUP, ACCESS, DONE}.
  - Default UART_ADDR constant.
  - Timeout counter width function.
- One sub-module, apb_uart_rr_arb: combinational round-robin pick from req and ptr, returning the grant index and an any_req flag. The FSM and APB registers stay in apb_uart_sched.

Test Plan:
- Single write: req[0]=1, req_write[0]=1, wdata 8'hA5; slave model returns pready after 12 cycles.
  - m_psel rises in the cycle after IDLE, m_penable one cycle later, m_pwdata=A5.
  - done[0] one cycle after pready sample; rsp_err=0.
- Single read: req[2] read; slave returns pready with prdata 8'h3C → done[2] pulses, rsp_rdata=3C, rsp_err=0, with one m_psel-low cycle before any next transfer.
- Fairness: req=4'b1111 held continuously → grant order 0,1,2,3,0 with one DONE gap between transfers. Then req=4'b1001 after grant 0 → next grant 3, then 0.
- Timeout: read where slave never asserts pready, TIMEOUT=16 → exactly 16 ACCESS cycles, then done with rsp_err=1, rsp_rdata=0; the next requester proceeds normally.
- Coincidence: m_pready asserted on the final timeout cycle → rsp_err=0 and data captured.
- Reset mid-ACCESS: presetn low for 2 cycles during a write → m_psel/m_penable low asynchronously, no done pulse; after release, requester 0 has priority again.
